// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
//
// Holds the architectural N/V/Z flag register and the program counter.
// Branch conditions are evaluated against the registered flags. The PC
// advances sequentially, takes PC-relative or register branches, and
// freezes in HALT until reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   alu_flag   ALU flag output {Z, V, N}
//   flag_we    load alu_flag into the flag register this cycle
//   stall      hold PC, flags, state and counter
//   is_b       conditional branch, PC-relative (imm9 in halfwords)
//   is_br      conditional branch to br_target
//   is_hlt     halt instruction
//   cond       condition code
//   imm9       signed branch offset in halfwords
//   br_target  register branch target
//   flag_out   registered flags, fed back to the ALU
//   pc         current PC
//   pc_plus2   pc + 2 (combinational)
//   taken      branch taken this cycle (combinational)
//   halted     high in HALT
//   taken_cnt  saturating count of taken branches
//
// Build option:
//   FLAG_BRANCH_CNT_EN  when defined, taken_cnt counts taken branches;
//                       otherwise taken_cnt is constant zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal fetch: PC and flags update unless stalled
// HALT  | PC and flags frozen, all control inputs ignored, exit by reset
// ---------------------------------------------------------------------------
module flag_branch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      alu_flag,
    input  logic            flag_we,
    input  logic            stall,
    input  logic            is_b,
    input  logic            is_br,
    input  logic            is_hlt,
    input  logic [2:0]      cond,
    input  logic [8:0]      imm9,
    input  logic [PC_W-1:0] br_target,
    output logic [2:0]      flag_out,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic            taken,
    output logic            halted,
    output logic [15:0]     taken_cnt
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [2:0]        flag_q;
    logic [2:0]        flag_d;
    logic              cond_true;
    logic              run;
    logic              advance;
    logic [PC_W-1:0]   br_offset;

    logic flag_n;
    logic flag_v;
    logic flag_z;

    assign flag_n = flag_q[0];
    assign flag_v = flag_q[1];
    assign flag_z = flag_q[2];

    assign run     = (state_q == S_RUN);
    assign advance = run & ~stall;

    assign pc_plus2 = pc_q + PC_W'(2);

    // Sign-extended halfword offset converted to a byte offset.
    assign br_offset = {{(PC_W-9){imm9[8]}}, imm9[7:0], 1'b0};

    // Conditions look only at the registered flags, so a flag write in the
    // same cycle as a branch does not affect that branch.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = ~flag_z;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = ~flag_z & ~flag_n;
            3'b011: cond_true = flag_n;
            3'b100: cond_true = flag_z | ~flag_n;
            3'b101: cond_true = flag_n | flag_z;
            3'b110: cond_true = flag_v;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign taken = (is_b | is_br) & cond_true & run & ~is_hlt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        if (advance) begin
            if (is_hlt) begin
                state_d = S_HALT;
            end else if (is_br && taken) begin
                pc_d = br_target;
            end else if (is_b && taken) begin
                pc_d = pc_plus2 + br_offset;
            end else begin
                pc_d = pc_plus2;
            end
            if (flag_we) begin
                flag_d = alu_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            flag_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
        end
    end

    assign pc       = pc_q;
    assign flag_out = flag_q;
    assign halted   = (state_q == S_HALT);

`ifdef FLAG_BRANCH_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else if (taken && !stall && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign taken_cnt = cnt_q;
`else
    assign taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  alu_flag;
    logic        flag_we;
    logic        stall;
    logic        is_b;
    logic        is_br;
    logic        is_hlt;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] br_target;
    logic [2:0]  flag_out;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        halted;
    logic [15:0] taken_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    flag_branch_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_flag  (alu_flag),
        .flag_we   (flag_we),
        .stall     (stall),
        .is_b      (is_b),
        .is_br     (is_br),
        .is_hlt    (is_hlt),
        .cond      (cond),
        .imm9      (imm9),
        .br_target (br_target),
        .flag_out  (flag_out),
        .pc        (pc),
        .pc_plus2  (pc_plus2),
        .taken     (taken),
        .halted    (halted),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        flag_we   = 1'b0;
        alu_flag  = 3'b000;
        stall     = 1'b0;
        is_b      = 1'b0;
        is_br     = 1'b0;
        is_hlt    = 1'b0;
        cond      = 3'b000;
        imm9      = 9'h000;
        br_target = 16'h0000;
    endtask

    // Expected taken_cnt after N unstalled taken branches.
    function automatic logic [15:0] exp_cnt(input int n);
`ifdef FLAG_BRANCH_CNT_EN
        return 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    logic [7:0] tbl_flags_n;
    logic [7:0] tbl_flags_vz;

    initial begin
        // Expected taken per cond (bit index = cond) for flags N=1 and for V=1,Z=1.
        tbl_flags_n  = 8'b1010_1001;
        tbl_flags_vz = 8'b1111_0010;

        clear_ctl();
        rst_n = 1'b0;
        #2;
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_flag", 32'(flag_out), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_cnt", 32'(taken_cnt), 32'h0000);
        #10;
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("seq_pc", 32'(pc), 32'(i * 2));
        end
        check("seq_flag", 32'(flag_out), 32'h0);
        check("seq_halted", 32'(halted), 32'h0);
        check("seq_pc_plus2", 32'(pc_plus2), 32'h000A);

        tick(); tick(); tick();
        check("pre_b_pc", 32'(pc), 32'h000E);

        // Load Z, then branch on EQ
        flag_we = 1'b1; alu_flag = 3'b100;
        tick();
        check("flag_z_pc", 32'(pc), 32'h0010);
        check("flag_z", 32'(flag_out), 32'h4);
        flag_we = 1'b0;
        is_b = 1'b1; cond = 3'b001; imm9 = 9'h004;
        #1;
        check("eq_taken", 32'(taken), 32'h1);
        tick();
        check("eq_pc", 32'(pc), 32'h001A);
        check("eq_cnt", 32'(taken_cnt), 32'(exp_cnt(1)));

        // Clear flags, then write N in the same cycle as an LT branch
        clear_ctl();
        flag_we = 1'b1; alu_flag = 3'b000;
        tick();
        check("clr_pc", 32'(pc), 32'h001C);
        check("clr_flag", 32'(flag_out), 32'h0);
        flag_we = 1'b1; alu_flag = 3'b001;
        is_b = 1'b1; cond = 3'b011; imm9 = 9'h004;
        #1;
        check("lt_old_taken", 32'(taken), 32'h0);
        tick();
        check("lt_old_pc", 32'(pc), 32'h001E);
        check("lt_new_flag", 32'(flag_out), 32'h1);
        flag_we = 1'b0;
        #1;
        check("lt_new_taken", 32'(taken), 32'h1);
        tick();
        check("lt_new_pc", 32'(pc), 32'h0028);

        // is_br beats is_b
        clear_ctl();
        is_b = 1'b1; is_br = 1'b1; cond = 3'b111; imm9 = 9'h004; br_target = 16'h1234;
        tick();
        check("br_pri_pc", 32'(pc), 32'h1234);
        is_b = 1'b0; br_target = 16'h0004;
        tick();
        check("br_pc", 32'(pc), 32'h0004);
        is_br = 1'b0; is_b = 1'b1; imm9 = 9'h1FF;
        tick();
        check("b_neg_pc", 32'(pc), 32'h0004);
        check("b_cnt", 32'(taken_cnt), 32'(exp_cnt(5)));

        // Stall: taken still visible, nothing updates
        stall = 1'b1; imm9 = 9'h004; flag_we = 1'b1; alu_flag = 3'b010;
        #1;
        check("stall_taken", 32'(taken), 32'h1);
        tick();
        check("stall_pc", 32'(pc), 32'h0004);
        check("stall_flag", 32'(flag_out), 32'h1);
        check("stall_cnt", 32'(taken_cnt), 32'(exp_cnt(5)));

        // Condition sweep with N=1 (stall holds state meanwhile)
        flag_we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            #1;
            check($sformatf("cond_n_%0d", c), 32'(taken), 32'(tbl_flags_n[c]));
        end
        clear_ctl();
        flag_we = 1'b1; alu_flag = 3'b110;
        tick();
        check("vz_pc", 32'(pc), 32'h0006);
        check("vz_flag", 32'(flag_out), 32'h6);
        clear_ctl();
        stall = 1'b1; is_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cond = 3'(c);
            #1;
            check($sformatf("cond_vz_%0d", c), 32'(taken), 32'(tbl_flags_vz[c]));
        end
        tick();
        check("sweep_cnt", 32'(taken_cnt), 32'(exp_cnt(5)));

        // Wrap-around
        clear_ctl();
        is_br = 1'b1; cond = 3'b111; br_target = 16'hFFFE;
        tick();
        check("wrap_pre_pc", 32'(pc), 32'hFFFE);
        check("wrap_pp2", 32'(pc_plus2), 32'h0000);
        clear_ctl();
        tick();
        check("wrap_pc", 32'(pc), 32'h0000);
        tick();
        check("pre_hlt_pc", 32'(pc), 32'h0002);

        // Halt
        is_hlt = 1'b1; is_b = 1'b1; cond = 3'b111; imm9 = 9'h010;
        #1;
        check("hlt_taken", 32'(taken), 32'h0);
        tick();
        check("hlt_pc", 32'(pc), 32'h0002);
        check("hlt_halted", 32'(halted), 32'h1);
        is_hlt = 1'b0; flag_we = 1'b1; alu_flag = 3'b111;
        #1;
        check("halt_taken", 32'(taken), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_pc", 32'(pc), 32'h0002);
            check("halt_halted", 32'(halted), 32'h1);
        end
        check("halt_flag", 32'(flag_out), 32'h6);
        check("halt_cnt", 32'(taken_cnt), 32'(exp_cnt(6)));

        // Asynchronous reset mid-cycle exits HALT
        rst_n = 1'b0;
        #2;
        check("arst_pc", 32'(pc), 32'h0000);
        check("arst_halted", 32'(halted), 32'h0);
        check("arst_flag", 32'(flag_out), 32'h0);
        check("arst_cnt", 32'(taken_cnt), 32'h0000);
        clear_ctl();
        rst_n = 1'b1;
        tick();
        check("post_rst_pc", 32'(pc), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumes the ALU's 3-bit FLAG output, holds it in the architectural flag register, and returns it to the ALU as FLAG_in.
- Evaluates branch conditions against the held flags and owns the PC register: sequential, branch-immediate, branch-register and halt.
- Sits between the ALU flag output and instruction fetch in the single-cycle datapath.

Parameters:
- PC_W, 16, width of the PC and the branch-target path
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_flag  input  3  ALU FLAG output: [0]=N, [1]=V, [2]=Z
- flag_we  input  1  capture alu_flag into the flag register this cycle
- stall  input  1  hold PC and flags; no state update
- is_b  input  1  conditional branch, PC-relative immediate
- is_br  input  1  conditional branch to register value
- is_hlt  input  1  halt instruction
- cond  input  3  condition code
- imm9  input  9  signed branch offset, in halfwords
- br_target  input  PC_W  register target for is_br
- flag_out  output  3  held flags, wired to the ALU FLAG_in
- pc  output  PC_W  current PC
- pc_plus2  output  PC_W  pc + 2, combinational
- taken  output  1  branch taken this cycle, combinational
- halted  output  1  block is in the HALT state
- taken_cnt  output  16  count of taken branches (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, flag_out = 3'b000, state = RUN, halted = 0, taken_cnt = 0.
- States:
  - RUN: normal operation.
  - HALT: PC and flags frozen, halted = 1.
  - Transitions: RUN->HALT on a rising edge with is_hlt=1 and stall=0. HALT->RUN only through reset.
- Condition truth (uses the registered flag_out, never alu_flag):
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or N=0
  - 101 LTE: N=1 or Z=1
  - 110 OVFL: V=1
  - 111 always true
- taken = (is_b | is_br) & cond_true & state==RUN & ~is_hlt.
- Next PC, in RUN with stall=0, priority from highest:
  - is_hlt: pc held (PC points at the HLT).
  - is_br & taken: br_target.
  - is_b & taken: pc_plus2 + (sign-extended imm9 << 1).
  - otherwise: pc_plus2.
- Arithmetic: all PC math is modulo 2^PC_W. Wrap-around is silent, e.g. 16'hFFFE + 2 = 16'h0000.
- is_b and is_br both high: is_br wins.
- Flag register:
  - Loads alu_flag on the clock edge where flag_we=1, stall=0 and state=RUN.
  - In the same cycle, a branch evaluates the old (registered) value; the new flags are visible next cycle.
- stall=1: PC, flags, state and taken_cnt are held. taken still reflects the combinational decision.
- HALT: flag_we, is_b, is_br, is_hlt and stall are ignored. taken=0.
- Latency: a branch decision is combinational. pc updates on the next rising edge, giving a one-cycle PC latency.
- Reset asserted mid-operation overrides everything immediately, including HALT.

Optional Feature:
- Macro: FLAG_BRANCH_CNT_EN.
- Defined: 16-bit taken_cnt increments on every clock edge where taken=1 and stall=0. It saturates at 16'hFFFF and clears on reset.
- Undefined: no counter logic; taken_cnt is tied to 16'h0000.

Test Plan:
1. Reset, then 4 cycles with no control inputs -> pc = 0000, 0002, 0004, 0006, 0008; flag_out=000; halted=0.
2. flag_we=1 with alu_flag=3'b100 (Z), then next cycle is_b=1, cond=001, imm9=9'h004 at pc=0010 -> taken=1; next pc = 0012+0008 = 001A.
3. flag_we=1 with alu_flag=3'b001 (N) in the same cycle as is_b, cond=011, with old flags=000 -> taken=0, pc += 2; next cycle flag_out=001.
4. is_br=1, cond=111, br_target=1234, with is_b=1 also asserted -> pc=1234. Then is_b with imm9=9'h1FF (-1) at pc=0004 -> pc=0004.
5. pc=FFFE, no branch -> pc wraps to 0000. Then is_hlt=1 -> halted=1 and pc frozen for 10 cycles despite is_b, cond=111. Pulse rst_n low mid-cycle -> pc=0000 immediately.
6. With FLAG_BRANCH_CNT_EN: 3 taken branches plus 1 taken branch under stall=1 -> taken_cnt=3. Without the macro -> taken_cnt=0.
